// File: rtl/ace_arb_pkg.sv
// Shared types and constants for the ACE read-address round-robin arbiter.
package ace_arb_pkg;

  localparam int unsigned IDX_W = 5;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ADDR,
    ARB_DATA
  } arb_state_t;

endpackage

// File: rtl/ace_ar_rr_arbiter_rr_pick.sv
// Round-robin pick: lowest requester above ptr, else lowest requester overall.
module rr_pick
  import ace_arb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 8
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]       ptr,
  output logic [IDX_W-1:0]       idx,
  output logic                   any
);

  logic [NUM_MASTERS-1:0] mask;
  logic [IDX_W-1:0]       lo_all;
  logic [IDX_W-1:0]       lo_mask;

  always_comb begin
    mask    = '0;
    lo_all  = '0;
    lo_mask = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      mask[i] = req[i] && (i > 32'(ptr));
    end
    // Scan downwards so the last hit is the lowest set bit.
    for (int unsigned i = NUM_MASTERS; i > 0; i--) begin
      if (req[i-1])  lo_all  = IDX_W'(i - 1);
      if (mask[i-1]) lo_mask = IDX_W'(i - 1);
    end
    idx = (|mask) ? lo_mask : lo_all;
    any = |req;
  end

endmodule

// File: rtl/ace_ar_rr_arbiter.sv
// ACE AR/R round-robin arbiter: one read transaction in flight, grant held
// from AR issue until the last R beat, priority rotates after each burst.
module ace_ar_rr_arbiter
  import ace_arb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 8,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned ID_W        = 4,
  parameter int unsigned DATA_W      = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_MASTERS-1:0]        m_arvalid,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_araddr,
  input  logic [NUM_MASTERS*ID_W-1:0]   m_arid,
  output logic [NUM_MASTERS-1:0]        m_arready,
  output logic                          s_arvalid,
  output logic [ADDR_W-1:0]             s_araddr,
  output logic [ID_W-1:0]               s_arid,
  input  logic                          s_arready,
  input  logic                          s_rvalid,
  input  logic [DATA_W-1:0]             s_rdata,
  input  logic                          s_rlast,
  output logic                          s_rready,
  output logic [NUM_MASTERS-1:0]        m_rvalid,
  output logic [DATA_W-1:0]             m_rdata,
  output logic                          m_rlast,
  input  logic [NUM_MASTERS-1:0]        m_rready,
  output logic                          grant_valid,
  output logic [IDX_W-1:0]              grant_idx
);

  arb_state_t             state;
  logic [IDX_W-1:0]       rr_ptr;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_any;
  logic [NUM_MASTERS-1:0] gsel;
  logic                   in_addr;
  logic                   in_data;

  rr_pick #(.NUM_MASTERS(NUM_MASTERS)) u_pick (
    .req (m_arvalid),
    .ptr (rr_ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARB_IDLE;
      grant_idx <= '0;
      rr_ptr    <= IDX_W'(NUM_MASTERS - 1);
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_any) begin
            grant_idx <= pick_idx;
            state     <= ARB_ADDR;
          end
        end
        ARB_ADDR: begin
          if (s_arvalid && s_arready) state <= ARB_DATA;
        end
        ARB_DATA: begin
          if (s_rvalid && s_rready && s_rlast) begin
            rr_ptr <= grant_idx;
            state  <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  assign in_addr     = (state == ARB_ADDR);
  assign in_data     = (state == ARB_DATA);
  assign grant_valid = in_addr || in_data;
  assign m_rdata     = s_rdata;
  assign m_rlast     = s_rlast;

  // One-hot decode of the grant keeps all per-master routing index-width agnostic.
  always_comb begin
    gsel     = '0;
    s_araddr = '0;
    s_arid   = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      gsel[i] = (grant_idx == IDX_W'(i));
      if (gsel[i]) begin
        s_araddr = m_araddr[i*ADDR_W +: ADDR_W];
        s_arid   = m_arid[i*ID_W +: ID_W];
      end
    end
    s_arvalid = in_addr && (|(m_arvalid & gsel));
    m_arready = (in_addr && s_arready) ? gsel : '0;
    m_rvalid  = (in_data && s_rvalid) ? gsel : '0;
    s_rready  = in_data && (|(m_rready & gsel));
  end

  // A granted master must hold arvalid until its AR handshake completes.
  a_arvalid_held: assert property (
    @(posedge clk) disable iff (rst) (state == ARB_ADDR) |-> s_arvalid
  );

endmodule
